// File: rtl/bcd_scan_driver.sv
// bcd_scan_driver: time-multiplexed BCD digit scanner feeding a seven-segment decoder.
// Holds a packed BCD value, walks one digit per prescaled slot, darkens each slot for
// a guard interval, blanks leading zeros and invalid nibbles, and swaps in new values
// only at frame boundaries so a frame never mixes old and new digits.
module bcd_scan_driver #(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned PRESCALE   = 50000,
  parameter int unsigned GUARD      = 2,
  parameter int unsigned BLANK_LEAD = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value_in,
  output logic [3:0]            bcd_out,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  pending,
  output logic                  err
);

  localparam int unsigned VAL_W = 4 * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t             state, state_n;
  logic [VAL_W-1:0]   active, active_n;
  logic [VAL_W-1:0]   shadow, shadow_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               pending_n, err_n;
  logic [3:0]         bcd_n;
  logic [DIGITS-1:0]  sel_n;

  logic               slot_end_c;
  logic               boundary_c;
  logic [DIGITS-1:0]  blank_c;
  logic [3:0]         nib_c;

  // Per-digit blank mask: invalid nibbles, plus leading zeros when enabled.
  function automatic logic [DIGITS-1:0] blank_mask(input logic [VAL_W-1:0] v);
    logic lead;
    blank_mask = '0;
    lead       = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lead          = lead && (v[4*i +: 4] == 4'd0);
      blank_mask[i] = (v[4*i +: 4] > 4'd9) || ((BLANK_LEAD != 0) && (i != 0) && lead);
    end
  endfunction

  // True when any nibble of the value is not a decimal digit.
  function automatic logic has_bad(input logic [VAL_W-1:0] v);
    has_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) has_bad = 1'b1;
    end
  endfunction

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      active    <= '0;
      shadow    <= '0;
      idx       <= '0;
      cnt       <= '0;
      pending   <= 1'b0;
      err       <= 1'b0;
      bcd_out   <= 4'd0;
      digit_sel <= '0;
    end else begin
      state     <= state_n;
      active    <= active_n;
      shadow    <= shadow_n;
      idx       <= idx_n;
      cnt       <= cnt_n;
      pending   <= pending_n;
      err       <= err_n;
      bcd_out   <= bcd_n;
      digit_sel <= sel_n;
    end
  end

  // Next-state logic; outputs are derived from the next state so they land with it.
  always_comb begin
    state_n    = state;
    active_n   = active;
    shadow_n   = shadow;
    idx_n      = idx;
    cnt_n      = cnt;
    pending_n  = pending;
    bcd_n      = 4'd0;
    sel_n      = '0;
    nib_c      = 4'd0;
    slot_end_c = (cnt == CNT_W'(PRESCALE - 1));
    boundary_c = slot_end_c && (idx == IDX_W'(DIGITS - 1));

    if (state == IDLE) begin
      if (load) begin
        active_n = value_in;
        state_n  = SCAN;
        idx_n    = '0;
        cnt_n    = '0;
      end
    end else begin
      if (slot_end_c) begin
        cnt_n = '0;
        idx_n = boundary_c ? '0 : IDX_W'(idx + IDX_W'(1));
      end else begin
        cnt_n = CNT_W'(cnt + CNT_W'(1));
      end

      if (boundary_c && load) begin
        active_n  = value_in;
        pending_n = 1'b0;
      end else if (boundary_c && pending) begin
        active_n  = shadow;
        pending_n = 1'b0;
      end else if (load) begin
        shadow_n  = value_in;
        pending_n = 1'b1;
      end
    end

    err_n   = has_bad(active_n);
    blank_c = blank_mask(active_n);

    if (state_n == SCAN) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (idx_n == IDX_W'(i)) nib_c = active_n[4*i +: 4];
      end
      bcd_n = (nib_c > 4'd9) ? 4'd0 : nib_c;
      for (int i = 0; i < DIGITS; i++) begin
        if ((idx_n == IDX_W'(i)) && (cnt_n >= CNT_W'(GUARD)) && !blank_c[i]) sel_n[i] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Directed bench for bcd_scan_driver with DIGITS=4, PRESCALE=4, GUARD=1, BLANK_LEAD=1.
module tb_bcd_scan_driver;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] value_in;
  logic [3:0]  bcd_out;
  logic [3:0]  digit_sel;
  logic        pending;
  logic        err;

  int checks = 0;
  int errors = 0;

  bcd_scan_driver #(
    .DIGITS(4), .PRESCALE(4), .GUARD(1), .BLANK_LEAD(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value_in(value_in),
    .bcd_out(bcd_out), .digit_sel(digit_sel), .pending(pending), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One 4-cycle slot: one dark guard cycle, then three lit cycles.
  task automatic chk_slot(input string tag, input logic [3:0] b, input logic [3:0] s);
    for (int c = 0; c < 4; c++) begin
      chk({tag, "_bcd"}, 16'(bcd_out), 16'(b));
      chk({tag, "_sel"}, 16'(digit_sel), (c == 0) ? 16'h0 : 16'(s));
      step();
    end
  endtask

  // Load at slot 0 cycle 0 and run to just past the next frame boundary.
  task automatic load_sync(input logic [15:0] v);
    value_in = v;
    load     = 1'b1;
    step();
    load     = 1'b0;
    repeat (15) step();
  endtask

  initial begin
    rst_n    = 1'b0;
    load     = 1'b0;
    value_in = 16'h0;
    #2;
    chk("rst_bcd", 16'(bcd_out), 16'h0);
    chk("rst_sel", 16'(digit_sel), 16'h0);
    chk("rst_pend", 16'(pending), 16'h0);
    chk("rst_err", 16'(err), 16'h0);
    repeat (2) step();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("idle_sel", 16'(digit_sel), 16'h0);
      chk("idle_bcd", 16'(bcd_out), 16'h0);
    end

    // Load from IDLE and scan two frames' worth of slots
    value_in = 16'h1234;
    load     = 1'b1;
    step();
    load     = 1'b0;
    chk("t1_err", 16'(err), 16'h0);
    chk_slot("t1_s0", 4'd4, 4'b0001);
    chk_slot("t1_s1", 4'd3, 4'b0010);
    chk_slot("t1_s2", 4'd2, 4'b0100);
    chk_slot("t1_s3", 4'd1, 4'b1000);
    chk_slot("t1_r0", 4'd4, 4'b0001);

    // Tear-free update: load during slot 1, old digits remain until the wrap
    value_in = 16'h9876;
    load     = 1'b1;
    step();
    load     = 1'b0;
    chk("t3_pend", 16'(pending), 16'h1);
    chk("t3_bcd1", 16'(bcd_out), 16'h3);
    chk("t3_sel1", 16'(digit_sel), 16'h2);
    repeat (3) step();
    chk_slot("t3_s2", 4'd2, 4'b0100);
    chk("t3_pend3", 16'(pending), 16'h1);
    chk_slot("t3_s3", 4'd1, 4'b1000);
    chk("t3_pend_wrap", 16'(pending), 16'h0);
    chk_slot("t3_n0", 4'd6, 4'b0001);
    chk_slot("t3_n1", 4'd7, 4'b0010);
    chk_slot("t3_n2", 4'd8, 4'b0100);
    chk_slot("t3_n3", 4'd9, 4'b1000);

    // Leading-zero blanking
    load_sync(16'h0050);
    chk("t2_pend", 16'(pending), 16'h0);
    chk_slot("t2a_s0", 4'd0, 4'b0001);
    chk_slot("t2a_s1", 4'd5, 4'b0010);
    chk_slot("t2a_s2", 4'd0, 4'b0000);
    chk_slot("t2a_s3", 4'd0, 4'b0000);
    load_sync(16'h0000);
    chk_slot("t2b_s0", 4'd0, 4'b0001);
    chk_slot("t2b_s1", 4'd0, 4'b0000);
    chk_slot("t2b_s2", 4'd0, 4'b0000);
    chk_slot("t2b_s3", 4'd0, 4'b0000);

    // Invalid digit, then recovery
    load_sync(16'h12A4);
    chk("t4_err", 16'(err), 16'h1);
    chk_slot("t4_s0", 4'd4, 4'b0001);
    chk_slot("t4_s1", 4'd0, 4'b0000);
    chk_slot("t4_s2", 4'd2, 4'b0100);
    chk_slot("t4_s3", 4'd1, 4'b1000);
    value_in = 16'h1234;
    load     = 1'b1;
    step();
    load     = 1'b0;
    chk("t4_pend", 16'(pending), 16'h1);
    chk("t4_err_hold", 16'(err), 16'h1);
    repeat (15) step();
    chk("t4_err_clr", 16'(err), 16'h0);
    chk_slot("t4_r0", 4'd4, 4'b0001);

    // Boundary collision: load on the wrap edge beats the pending shadow
    value_in = 16'h1111;
    load     = 1'b1;
    step();
    load     = 1'b0;
    chk("t5_pend", 16'(pending), 16'h1);
    repeat (10) step();
    chk("t5_pre_bcd", 16'(bcd_out), 16'h1);
    chk("t5_pre_sel", 16'(digit_sel), 16'h8);
    value_in = 16'h2222;
    load     = 1'b1;
    step();
    load     = 1'b0;
    chk("t5_pend_clr", 16'(pending), 16'h0);
    chk_slot("t5_s0", 4'd2, 4'b0001);
    chk_slot("t5_s1", 4'd2, 4'b0010);
    chk_slot("t5_s2", 4'd2, 4'b0100);
    chk_slot("t5_s3", 4'd2, 4'b1000);

    // Async reset mid-slot while digit 2 is lit
    value_in = 16'h1234;
    load     = 1'b1;
    step();
    load     = 1'b0;
    repeat (9) step();
    chk("t6_pre_sel", 16'(digit_sel), 16'h4);
    chk("t6_pre_bcd", 16'(bcd_out), 16'h2);
    chk("t6_pre_pend", 16'(pending), 16'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_sel", 16'(digit_sel), 16'h0);
    chk("t6_rst_bcd", 16'(bcd_out), 16'h0);
    chk("t6_rst_pend", 16'(pending), 16'h0);
    chk("t6_rst_err", 16'(err), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t6_dark_sel", 16'(digit_sel), 16'h0);
      chk("t6_dark_bcd", 16'(bcd_out), 16'h0);
    end
    value_in = 16'h0007;
    load     = 1'b1;
    step();
    load     = 1'b0;
    chk_slot("t6_s0", 4'd7, 4'b0001);
    chk_slot("t6_s1", 4'd0, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_scan_driver.md
# bcd_scan_driver

Time-multiplexing driver that sits directly upstream of the 4-bit BCD-to-seven-segment decoder. It holds a packed multi-digit BCD value and presents one digit at a time on `bcd_out`, which drives the decoder's `data` input. It also asserts a one-hot digit enable for the matching display position. Features: programmable refresh prescaler, anti-ghosting guard interval, leading-zero blanking, invalid-digit detection, and tear-free value updates at frame boundaries.

## Interface
- `DIGITS`, 4: number of display positions; index `DIGITS-1` is the most significant.
- `PRESCALE`, 50000: clock cycles per digit slot; must be ≥ `GUARD`+1.
- `GUARD`, 2: cycles at slot start with all enables low; may be 0.
- `BLANK_LEAD`, 1: 1 = suppress leading zeros.
- `clk`  in  1  single clock; all flops on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `load`  in  1  single-cycle request to accept `value_in`.
- `value_in`  in  4*DIGITS  packed BCD; nibble i is at [4i+3:4i].
- `bcd_out`  out  4  current digit code to the seven-segment decoder.
- `digit_sel`  out  DIGITS  one-hot active-high digit enable; all zero when dark.
- `pending`  out  1  a loaded value is waiting for the frame boundary.
- `err`  out  1  the active value contains a nibble > 9.

## Operation
- **Reset** (rst_n low, effective immediately):
  - `bcd_out`=0, `digit_sel`=0, `pending`=0, `err`=0.
  - Active and shadow registers = 0; prescaler = 0; index = 0; state = IDLE.
- **IDLE**:
  - `digit_sel`=0 and `bcd_out`=0.
  - `load` copies `value_in` directly into the active register.
  - Next state is SCAN with index=0 and prescaler=0.
- **SCAN, prescaler**:
  - Counts 0..PRESCALE-1.
  - At PRESCALE-1 it returns to 0 and index advances; DIGITS-1 wraps to 0.
  - The edge where index wraps DIGITS-1→0 is the frame boundary.
- **SCAN, `bcd_out`**: equals active nibble[index]; forced to 0 if that nibble > 9.
- **SCAN, `digit_sel`**: equals onehot(index) when prescaler ≥ GUARD and digit `index` is not blanked; otherwise 0.
- **Blanking**: digit i is blanked if either of the following holds.
  - Its nibble > 9.
  - BLANK_LEAD=1, i ≠ 0, and nibbles DIGITS-1 down to i are all zero. Digit 0 is never zero-blanked.
- **Load in SCAN**:
  - Not on a boundary edge: `value_in` → shadow, `pending`←1. A later load before the boundary overwrites the shadow.
  - On the frame boundary edge with `pending`=1: shadow → active, `pending`←0.
  - Load sampled on the boundary edge itself: `value_in` goes straight to active (it wins over the shadow), and `pending`←0.
- **`err`**: recomputed whenever the active register is written; 1 if any nibble > 9, else 0.
- SCAN never returns to IDLE except through reset.

## Timing
- All outputs are registered and reflect the state after the same clock edge. There are no combinational input→output paths.
- Load in IDLE at edge N: from edge N+1, state is SCAN with index 0 and prescaler 0.
- Frame length is DIGITS×PRESCALE cycles.
- Each slot has GUARD dark cycles followed by PRESCALE-GUARD lit cycles.
- A load in SCAN takes effect at the next frame boundary, at most DIGITS×PRESCALE cycles later. The display never shows a mix of old and new digits within one frame.
- Deasserting reset mid-frame restarts in IDLE, dark, waiting for a load.

## Test plan
All scenarios use DIGITS=4, PRESCALE=4, GUARD=1, BLANK_LEAD=1.
1. **Load from IDLE**: after reset, pulse `load` with value 0x1234. Required:
   - Slot 0: `bcd_out`=4; `digit_sel`=0000 for 1 cycle, then 0001 for 3 cycles.
   - Slots 1–3 in order: 3/0010, 2/0100, 1/1000, each on the same pattern.
   - Frame repeats every 16 cycles.
2. **Leading-zero blanking**:
   - Load 0x0050: digits 3 and 2 keep `digit_sel`=0; digit 1 shows 5 (0010); digit 0 shows 0 (0001).
   - Load 0x0000: only 0001 ever asserts.
3. **Tear-free update**: in frame showing 0x1234, load 0x9876 during slot 1. Required:
   - `pending`=1 next cycle; remaining slots still show 2 and 1.
   - At the wrap edge, `pending`=0 and slot 0 shows 6.
4. **Invalid digit**:
   - Load 0x12A4: `err`=1 once applied; during slot 1, `bcd_out`=0 and `digit_sel`=0000; other digits display normally.
   - Then load 0x1234: `err`=0 after the next boundary.
5. **Boundary collision**: with `pending`=1 (shadow 0x1111), load 0x2222 on the wrap edge. Required: active=0x2222, `pending`=0, slot 0 shows 2.
6. **Async reset mid-slot**: drop `rst_n` between clock edges while `digit_sel`=0100. Required:
   - All outputs go to 0 without a clock edge.
   - After release, outputs stay dark until a load arrives.
